ntt_iter: RTL and testbench
===========================

Name: ntt_iter

Overview:
Sequential, parametrised successor to the combinational `ntt` block. It accepts a D-point coefficient vector serially, computes the cyclic forward or inverse NTT mod Q in place with one radix-2 butterfly per cycle, then streams the result out in natural order. Throughput is traded for area, so larger D and W become feasible. It sits between the coefficient source and the pointwise multiplier in the polynomial datapath.

Parameters:
W, 9, coefficient width in bits; requires Q < 2^W
LOG_D, 3, log2 of transform length; D = 2^LOG_D
Q, 257, prime modulus; D must divide Q-1
OMEGA, 4, primitive D-th root of unity mod Q
OMEGA_INV, 193, OMEGA^-1 mod Q
D_INV, 225, D^-1 mod Q

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  input coefficient valid
in_ready  out  1  block can accept a coefficient
in_data  in  W  coefficient, index order 0..D-1
inverse  in  1  0 = forward, 1 = inverse; sampled with coefficient 0
out_valid  out  1  output coefficient valid
out_ready  in  1  consumer accepts the output coefficient
out_data  out  W  result coefficient, index order 0..D-1, value < Q
busy  out  1  high in COMPUTE and UNLOAD

Behaviour:
- Reset, asynchronous on rst_n low: state LOAD, all counters 0, in_ready=1, out_valid=0, out_data=0, busy=0, mode=0. Memory contents are don't-care.
- LOAD:
  - in_ready=1.
  - A handshake (in_valid & in_ready) writes in_data mod Q to address bitrev(cnt), then increments cnt.
  - The mode register latches `inverse` on the cnt==0 handshake.
  - The handshake with cnt==D-1 moves to COMPUTE and clears cnt.
- COMPUTE:
  - in_ready=0, busy=1. Radix-2 DIT over stages s=0..LOG_D-1, with D/2 butterflies per stage, one per cycle.
  - Pair distance h=2^s. Twiddle is w^(j*(D/(2h))), where w = OMEGA (forward) or OMEGA_INV (inverse).
  - Butterfly: u'=(u+t*v) mod Q, v'=(u-t*v) mod Q. Product is 2W bits, reduced mod Q.
  - Both results are written back the same cycle. Stage s+1 reads only results written by stage s.
  - COMPUTE lasts exactly (D/2)*LOG_D cycles (12 at defaults), then the state moves to UNLOAD.
- UNLOAD:
  - out_valid=1, out_data=mem[cnt], multiplied by D_INV mod Q when mode=1, combinational from the memory read.
  - A handshake (out_valid & out_ready) increments cnt. out_data must stay stable while out_ready=0.
  - The handshake at cnt==D-1 returns to LOAD with cnt=0 and out_valid=0 on the next cycle.
- Latency: first out_valid occurs (D/2)*LOG_D+1 rising edges after the edge accepting the last input (13 at defaults).
- in_valid outside LOAD is ignored; no data is lost because in_ready=0.
- out_ready outside UNLOAD is ignored.
- `inverse` changes after coefficient 0 have no effect until the next frame.
- Reset mid-LOAD, mid-COMPUTE or mid-UNLOAD aborts the frame. The next frame starts fresh with index 0.
- All modular adds and subtracts use a single conditional correction, since inputs are already < Q.

Decomposition:
- Package ntt_pkg holds:
  - function bitrev(idx, LOG_D)
  - function modmul(a, b, Q)
  - function modpow for the twiddle ROM initialisation
  - state enum {LOAD, COMPUTE, UNLOAD}
- Sub-module ntt_butterfly (combinational: u, v, twiddle -> u', v'), parametrised by W and Q. The pointwise multiplier reuses it.
- Twiddle ROM: D/2 entries each for forward and inverse, generated at elaboration from OMEGA and OMEGA_INV.

Test Plan:
- Forward, all-ones input (8 × 1) -> out = [8,0,0,0,0,0,0,0]; first out_valid 13 cycles after the last input.
- Forward, impulse [1,0,0,0,0,0,0,0] -> out all 1. Then inverse on [8,0,...,0] -> out all 1 (D_INV scaling checked).
- Round trip: forward on [3,1,4,1,5,9,2,6], outputs fed back with inverse=1 -> [3,1,4,1,5,9,2,6]. Run 100 random frames against a reference model mod 257.
- Backpressure: out_ready toggled 1,0,0,1,... -> out_data stable while stalled, all 8 values in order, no duplicates. in_valid held high throughout COMPUTE and UNLOAD -> no extra writes, and the next frame starts correctly.
- Reset asserted at COMPUTE cycle 5 -> outputs take reset values immediately. A following all-ones frame yields [8,0,...,0].
- Parameter sweep LOG_D=4, Q=257, OMEGA=2, OMEGA_INV=129, D_INV=241: all-ones -> [16,0,...,0], with 33 cycles of latency.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and elaboration-time helpers for the iterative NTT datapath.
package ntt_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    // Reverse the low log_d bits of idx (input scatter for in-place DIT).
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned log_d);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 32'd0; i < log_d; i++) begin
            r = r | (((idx >> i) & 32'd1) << (log_d - 32'd1 - i));
        end
        return r;
    endfunction

    // (a * b) mod q on wide integers; only used for constant generation.
    function automatic longint unsigned modmul(input longint unsigned a,
                                               input longint unsigned b,
                                               input longint unsigned q);
        return (a * b) % q;
    endfunction

    // base^e mod q by repeated multiplication; e stays small (< D/2).
    function automatic longint unsigned modpow(input longint unsigned base,
                                               input longint unsigned e,
                                               input longint unsigned q);
        longint unsigned r;
        r = 64'd1 % q;
        for (longint unsigned i = 64'd0; i < e; i++) begin
            r = modmul(r, base % q, q);
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational radix-2 butterfly mod Q: u' = u + t*v, v' = u - t*v.
// Operands are assumed already reduced (< Q), so one correction suffices.
module ntt_butterfly #(
    parameter int W = 9,
    parameter int Q = 257
) (
    input  logic [W-1:0] u,
    input  logic [W-1:0] v,
    input  logic [W-1:0] tw,
    output logic [W-1:0] u_out,
    output logic [W-1:0] v_out
);

    localparam logic [2*W-1:0] QP = (2*W)'(Q);
    localparam logic [W:0]     QE = (W+1)'(Q);

    logic [2*W-1:0] prod;
    logic [W-1:0]   t;
    logic [W:0]     sum;

    // Twiddle product, then modular add and subtract with one correction each.
    always_comb begin
        prod = {{W{1'b0}}, tw} * {{W{1'b0}}, v};
        t    = W'(prod % QP);
        sum  = {1'b0, u} + {1'b0, t};
        if (sum >= QE) begin
            u_out = W'(sum - QE);
        end else begin
            u_out = W'(sum);
        end
        if (u >= t) begin
            v_out = u - t;
        end else begin
            v_out = W'({1'b0, u} + QE - {1'b0, t});
        end
    end

endmodule

// File: rtl/ntt_iter.sv
// Iterative in-place NTT: serial load (bit-reversed), one butterfly per
// cycle over LOG_D stages, then natural-order streaming output.
module ntt_iter
    import ntt_pkg::*;
#(
    parameter int W         = 9,
    parameter int LOG_D     = 3,
    parameter int Q         = 257,
    parameter int OMEGA     = 4,
    parameter int OMEGA_INV = 193,
    parameter int D_INV     = 225
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    localparam int D = 1 << LOG_D;
    localparam int H = D / 2;
    localparam logic [LOG_D-1:0] CNT_LAST = LOG_D'(D - 1);
    localparam logic [LOG_D-1:0] BF_LAST  = LOG_D'(H - 1);
    localparam logic [LOG_D-1:0] ST_LAST  = LOG_D'(LOG_D - 1);
    localparam logic [W-1:0]     QW       = W'(Q);
    localparam logic [W-1:0]     DINV     = W'(D_INV);
    localparam logic [2*W-1:0]   QP       = (2*W)'(Q);

    state_t           state, state_n;
    logic [LOG_D-1:0] cnt, cnt_n, stage, stage_n;
    logic             mode, mode_n, ov, ov_n;

    logic [W-1:0]     mem [D];
    logic [W-1:0]     tw_fwd [H];
    logic [W-1:0]     tw_inv [H];

    logic [LOG_D-1:0] hmask, ia, ib, shamt, ld_addr;
    logic [LOG_D-2:0] tw_idx;
    logic [W-1:0]     twiddle, bf_u, bf_v, in_mod, rd, scaled;
    logic [2*W-1:0]   sprod;

    // Twiddle ROMs: w^k for k < D/2, built at elaboration.
    for (genvar k = 0; k < H; k++) begin : g_tw
        assign tw_fwd[k] = W'(modpow(64'(OMEGA), 64'(k), 64'(Q)));
        assign tw_inv[k] = W'(modpow(64'(OMEGA_INV), 64'(k), 64'(Q)));
    end

    // Butterfly addressing: pair distance h = 2^stage, twiddle exponent j*(D/2h).
    always_comb begin
        hmask   = (LOG_D'(1) << stage) - LOG_D'(1);
        ia      = ((cnt & ~hmask) << 1) | (cnt & hmask);
        ib      = ia | (LOG_D'(1) << stage);
        shamt   = ST_LAST - stage;
        tw_idx  = (LOG_D-1)'((cnt & hmask) << shamt);
        twiddle = mode ? tw_inv[tw_idx] : tw_fwd[tw_idx];
        ld_addr = LOG_D'(bitrev(32'(cnt), 32'(LOG_D)));
        in_mod  = in_data % QW;
    end

    ntt_butterfly #(.W(W), .Q(Q)) u_bf (
        .u     (mem[ia]),
        .v     (mem[ib]),
        .tw    (twiddle),
        .u_out (bf_u),
        .v_out (bf_v)
    );

    // Output path: read mem[cnt], scale by D^-1 for inverse, zero when idle.
    always_comb begin
        rd    = mem[cnt];
        sprod = {{W{1'b0}}, rd} * {{W{1'b0}}, DINV};
        scaled = W'(sprod % QP);
        if (ov) begin
            out_data = mode ? scaled : rd;
        end else begin
            out_data = {W{1'b0}};
        end
    end

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign out_valid = ov;

    // Next-state and counter logic for LOAD -> COMPUTE -> UNLOAD.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stage_n = stage;
        mode_n  = mode;
        ov_n    = 1'b0;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    if (cnt == {LOG_D{1'b0}}) begin
                        mode_n = inverse;
                    end else begin
                        mode_n = mode;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt_n   = {LOG_D{1'b0}};
                        state_n = COMPUTE;
                    end else begin
                        cnt_n = cnt + LOG_D'(1);
                    end
                end else begin
                    cnt_n = cnt;
                end
            end
            COMPUTE: begin
                if (cnt == BF_LAST) begin
                    cnt_n = {LOG_D{1'b0}};
                    if (stage == ST_LAST) begin
                        stage_n = {LOG_D{1'b0}};
                        state_n = UNLOAD;
                    end else begin
                        stage_n = stage + LOG_D'(1);
                    end
                end else begin
                    cnt_n = cnt + LOG_D'(1);
                end
            end
            UNLOAD: begin
                ov_n = 1'b1;
                if (ov && out_ready) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = {LOG_D{1'b0}};
                        state_n = LOAD;
                        ov_n    = 1'b0;
                    end else begin
                        cnt_n = cnt + LOG_D'(1);
                    end
                end else begin
                    cnt_n = cnt;
                end
            end
            default: begin
                state_n = LOAD;
                cnt_n   = {LOG_D{1'b0}};
                stage_n = {LOG_D{1'b0}};
            end
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= {LOG_D{1'b0}};
            stage <= {LOG_D{1'b0}};
            mode  <= 1'b0;
            ov    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            stage <= stage_n;
            mode  <= mode_n;
            ov    <= ov_n;
        end
    end

    // Coefficient memory: scattered load writes, then in-place butterfly writes.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem[ld_addr] <= in_mod;
        end else if (state == COMPUTE) begin
            mem[ia] <= bf_u;
            mem[ib] <= bf_v;
        end
    end

endmodule

// File: tb/tb_ntt_iter.sv
// Randomised self-checking bench for ntt_iter against a direct O(D^2) DFT mod Q.
module tb_ntt_iter;

    localparam int W = 9;
    localparam int Q = 257;
    localparam int D = 8;
    localparam int OMEGA = 4;
    localparam int OMEGA_INV = 193;
    localparam int D_INV = 225;
    localparam int LAT = 13;

    logic clk, rst_n;
    logic in_valid, in_ready, inverse, out_valid, out_ready, busy;
    logic [W-1:0] in_data, out_data;
    logic in16_valid, in16_ready, out16_valid, out16_ready, busy16;
    logic [W-1:0] in16_data, out16_data;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_accept = 0;
    int rdy_mode = 0;
    int expq[$];
    int got[$];

    ntt_iter #(.W(W), .LOG_D(3), .Q(Q), .OMEGA(OMEGA), .OMEGA_INV(OMEGA_INV), .D_INV(D_INV)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inverse(inverse), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

    ntt_iter #(.W(W), .LOG_D(4), .Q(Q), .OMEGA(2), .OMEGA_INV(129), .D_INV(241)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in16_valid), .in_ready(in16_ready), .in_data(in16_data),
        .inverse(1'b0), .out_valid(out16_valid), .out_ready(out16_ready), .out_data(out16_data), .busy(busy16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic die(input string name);
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    endtask

    function automatic longint mpow(input int b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // Textbook DFT: y[k] = scale * sum_j x[j] * w^(j*k) mod Q.
    function automatic void dft(input int xs[$], input int w, input int scale, output int ys[$]);
        int n = xs.size();
        longint acc;
        ys = {};
        for (int k = 0; k < n; k++) begin
            acc = 0;
            for (int j = 0; j < n; j++)
                acc = (acc + longint'(xs[j] % Q) * mpow(w, (j * k) % n)) % Q;
            ys.push_back(int'((acc * scale) % Q));
        end
    endfunction

    task automatic put(input int x, input bit inv);
        int n = 0;
        in_valid = 1'b1;
        in_data = W'(x);
        inverse = inv;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) die("put_wait");
        end
        @(posedge clk);
        #1;
        last_accept = cyc;
    endtask

    task automatic send_frame(input int xs[$], input bit inv, input bit gaps, input bit hold);
        int ys[$];
        for (int i = 0; i < xs.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            put(xs[i], (i == 0) ? inv : 1'($urandom_range(0, 1)));
        end
        dft(xs, inv ? OMEGA_INV : OMEGA, inv ? D_INV : 1, ys);
        foreach (ys[k]) expq.push_back(ys[k]);
        in_valid = hold;
        in_data = hold ? W'($urandom_range(0, 511)) : {W{1'b0}};
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            n++;
            if (n > 600) die("drain_wait");
        end
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
    initial begin
        int ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output checker: every valid output against the model queue, latency, stall stability.
    initial begin
        int idx = 0;
        bit first = 1'b1;
        bit prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = 0; first = 1'b1; prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid) begin
                    if (expq.size() == 0) begin
                        chk("spurious_valid", 32'(out_valid), 32'd0);
                    end else begin
                        if (first) begin
                            chk("latency", 32'(cyc - last_accept), 32'(LAT));
                            first = 1'b0;
                        end
                        chk("data", 32'(out_data), 32'(expq[0]));
                        chk("busy_unload", 32'(busy), 32'd1);
                        if (out_ready) begin
                            got.push_back(int'(out_data));
                            void'(expq.pop_front());
                            idx++;
                            if (idx == D) begin idx = 0; first = 1'b1; end
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    initial begin
        int ones[$], imp[$], eight[$], pi[$], ys[$], rt[$], xs[$];
        ones = '{1, 1, 1, 1, 1, 1, 1, 1};
        imp = '{1, 0, 0, 0, 0, 0, 0, 0};
        eight = '{8, 0, 0, 0, 0, 0, 0, 0};
        pi = '{3, 1, 4, 1, 5, 9, 2, 6};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inverse = 1'b0;
        in16_valid = 1'b0; in16_data = '0; out16_ready = 1'b1;

        // Reset values and model pins.
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        dft(ones, OMEGA, 1, ys);
        foreach (ys[k]) chk("model_ones", 32'(ys[k]), (k == 0) ? 32'd8 : 32'd0);
        dft(imp, OMEGA, 1, ys);
        foreach (ys[k]) chk("model_impulse", 32'(ys[k]), 32'd1);
        dft(eight, OMEGA_INV, D_INV, ys);
        foreach (ys[k]) chk("model_inv8", 32'(ys[k]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed frames.
        got.delete();
        send_frame(ones, 1'b0, 1'b0, 1'b0);
        wait_drain();
        foreach (got[k]) chk("ones_out", 32'(got[k]), (k == 0) ? 32'd8 : 32'd0);
        chk("ones_count", 32'(got.size()), 32'd8);
        got.delete();
        send_frame(imp, 1'b0, 1'b0, 1'b0);
        send_frame(eight, 1'b1, 1'b0, 1'b0);
        wait_drain();
        foreach (got[k]) chk("imp_inv8_out", 32'(got[k]), 32'd1);

        // Round trip.
        got.delete();
        send_frame(pi, 1'b0, 1'b0, 1'b0);
        wait_drain();
        rt = got;
        got.delete();
        send_frame(rt, 1'b1, 1'b0, 1'b0);
        wait_drain();
        foreach (got[k]) chk("round_trip", 32'(got[k]), 32'(pi[k]));

        // Backpressure pattern plus in_valid held high through COMPUTE/UNLOAD.
        rdy_mode = 1;
        got.delete();
        send_frame(pi, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send_frame(ones, 1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("bp_count", 32'(got.size()), 32'd16);
        for (int k = 8; k < got.size(); k++) chk("bp_second", 32'(got[k]), (k == 8) ? 32'd8 : 32'd0);

        // Reset in the middle of COMPUTE.
        rdy_mode = 0;
        send_frame(ones, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        expq.delete();
        got.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(ones, 1'b0, 1'b0, 1'b0);
        wait_drain();
        foreach (got[k]) chk("post_rst_out", 32'(got[k]), (k == 0) ? 32'd8 : 32'd0);

        // Random frames with gaps, random ready, random hold-high.
        rdy_mode = 2;
        for (int f = 0; f < 100; f++) begin
            bit hold;
            xs = {};
            for (int i = 0; i < D; i++) xs.push_back(int'($urandom_range(0, 511)));
            hold = (f != 99) && ($urandom_range(0, 1) == 1);
            send_frame(xs, 1'($urandom_range(0, 1)), 1'b1, hold);
            if (hold) begin
                repeat ($urandom_range(0, 15)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
        rdy_mode = 0;

        // 16-point instance: all ones -> [16,0,...], 33 cycles latency.
        begin
            int n = 0;
            int last16 = 0;
            for (int i = 0; i < 16; i++) begin
                in16_valid = 1'b1;
                in16_data = 9'd1;
                n = 0;
                forever begin
                    @(negedge clk);
                    if (in16_ready) break;
                    n++;
                    if (n > 100) die("put16_wait");
                end
                @(posedge clk); #1;
                last16 = cyc;
            end
            in16_valid = 1'b0;
            n = 0;
            forever begin
                @(negedge clk);
                if (out16_valid) break;
                n++;
                if (n > 100) die("out16_wait");
            end
            chk("latency16", 32'(cyc - last16), 32'd33);
            for (int k = 0; k < 16; k++) begin
                if (k > 0) @(negedge clk);
                chk("valid16", 32'(out16_valid), 32'd1);
                chk("data16", 32'(out16_data), (k == 0) ? 32'd16 : 32'd0);
            end
            @(negedge clk);
            chk("done16", 32'(out16_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
